// File: rtl/mips_load_pkg.sv
// Shared constants and state encoding for the instruction-memory stream loader.
package mips_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } load_state_e;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
    localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_word_packer.sv
// Packs bytes MSB-first into instruction words and keeps a running XOR of every byte.
module byte_word_packer
    import mips_load_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o,
    output logic [7:0]        csum_o,
    output logic              word_done_c
);

    logic [BCNT_W-1:0] cnt_q;
    logic [WORD_W-9:0] shift_q;
    logic [WORD_W-1:0] word_q;
    logic              word_valid_q;
    logic [7:0]        csum_q;

    // Last byte of a word is being accepted this cycle.
    assign word_done_c = valid_i && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            csum_q       <= '0;
        end else begin
            word_valid_q <= word_done_c;
            if (clear_i) begin
                cnt_q   <= '0;
                shift_q <= '0;
                csum_q  <= '0;
            end else if (valid_i) begin
                cnt_q   <= word_done_c ? '0 : cnt_q + BCNT_W'(1);
                shift_q <= {shift_q[WORD_W-17:0], byte_i};
                csum_q  <= csum_q ^ byte_i;
                if (word_done_c) begin
                    word_q <= {shift_q, byte_i};
                end
            end
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;
    assign csum_o       = csum_q;

endmodule

// File: rtl/imem_stream_loader.sv
// Loads a length-prefixed, XOR-checked byte stream into the IM word array and
// releases the CPU from reset only once a complete, verified image is in place.
module imem_stream_loader
    import mips_load_pkg::*;
#(
    parameter int unsigned IM_ADDR_W = 10,
    parameter int unsigned LEN_W     = 16
)
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 im_we,
    output logic [IM_ADDR_W-1:0] im_addr,
    output logic [WORD_W-1:0]    im_wdata,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error,
    output logic [LEN_W-1:0]     words_loaded
);

    localparam int unsigned LEN_HI_W = LEN_W - 8 * (HDR_BYTES - 1);
    localparam int unsigned AW1      = IM_ADDR_W + 1;
    localparam int unsigned LW1      = LEN_W + 1;
    localparam logic [LEN_W:0] MAX_WORDS = LW1'(1) << IM_ADDR_W;

    load_state_e           state_q, state_d;
    logic [LEN_HI_W-1:0]   len_hi_q, len_hi_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [AW1-1:0]        addr_q, addr_d;
    logic [IM_ADDR_W-1:0]  im_addr_q, im_addr_d;
    logic [LEN_W-1:0]      words_q, words_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  hold_q, hold_d;
    logic                  in_ready_q, in_ready_d;

    logic                  accept_c;
    logic                  clear_c;
    logic [LEN_W-1:0]      len_c;
    logic                  word_done_c;
    logic                  word_valid;
    logic [WORD_W-1:0]     word;
    logic [7:0]            csum;

    assign accept_c = in_valid && in_ready_q;
    assign len_c    = {len_hi_q, in_data};

    byte_word_packer u_packer (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (clear_c),
        .valid_i      (accept_c && (state_q == ST_DATA)),
        .byte_i       (in_data),
        .word_o       (word),
        .word_valid_o (word_valid),
        .csum_o       (csum),
        .word_done_c  (word_done_c)
    );

    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        addr_d    = addr_q;
        im_addr_d = im_addr_q;
        words_d   = words_q;
        done_d    = done_q;
        error_d   = error_q;
        hold_d    = hold_q;
        clear_c   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    clear_c   = 1'b1;
                    state_d   = ST_LEN_HI;
                    hold_d    = 1'b1;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    words_d   = '0;
                    addr_d    = '0;
                    im_addr_d = '0;
                end
            end
            ST_LEN_HI: begin
                if (accept_c) begin
                    len_hi_d = LEN_HI_W'(in_data);
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept_c) begin
                    len_d = len_c;
                    if (len_c == '0) begin
                        state_d = ST_CSUM;
                    end else if ({1'b0, len_c} > MAX_WORDS) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Word index is latched here so the strobe cycle shows the word just completed.
                if (word_done_c) begin
                    im_addr_d = addr_q[IM_ADDR_W-1:0];
                    addr_d    = addr_q + AW1'(1);
                    words_d   = words_q + LEN_W'(1);
                    if (LEN_W'(addr_q) + LEN_W'(1) == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept_c) begin
                    if (in_data == csum) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                     (state_d == ST_DATA)   || (state_d == ST_CSUM);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_hi_q   <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            im_addr_q  <= '0;
            words_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            hold_q     <= 1'b1;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            im_addr_q  <= im_addr_d;
            words_q    <= words_d;
            done_q     <= done_d;
            error_q    <= error_d;
            hold_q     <= hold_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign im_we        = word_valid;
    assign im_addr      = im_addr_q;
    assign im_wdata     = word;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed and random frames against a frame-level reference model; a second
// instance with a 4-word IM covers the length-overflow and full-size boundaries.
module tb_imem_stream_loader;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          wl;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;

    logic        in_ready, im_we, cpu_hold, done, error;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic [15:0] words_loaded;

    logic        in_ready_s, im_we_s, cpu_hold_s, done_s, error_s;
    logic [1:0]  im_addr_s;
    logic [31:0] im_wdata_s;
    logic [15:0] words_loaded_s;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          sel = 1'b0;
    logic [7:0]  frame[$];
    wr_t         wr_q[$];
    wr_t         wrs_q[$];

    imem_stream_loader #(.IM_ADDR_W(10), .LEN_W(16)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    imem_stream_loader #(.IM_ADDR_W(2), .LEN_W(16)) dut_s (
        .clock(clock), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s),
        .im_we(im_we_s), .im_addr(im_addr_s), .im_wdata(im_wdata_s),
        .cpu_hold(cpu_hold_s), .done(done_s), .error(error_s),
        .words_loaded(words_loaded_s)
    );

    always #5 clock = ~clock;

    // IM write log, sampled mid-cycle.
    always @(negedge clock) begin
        if (im_we)
            wr_q.push_back('{addr: int'(im_addr), data: im_wdata, wl: int'(words_loaded)});
        if (im_we_s)
            wrs_q.push_back('{addr: int'(im_addr_s), data: im_wdata_s, wl: int'(words_loaded_s)});
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_ready();
        return sel ? in_ready_s : in_ready;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!cur_ready() && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) chk("handshake_timeout", 64'(t), 64'(0));
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".in_ready"}, 64'(sel ? in_ready_s : in_ready), 64'(0));
        chk({tag, ".im_we"},    64'(sel ? im_we_s : im_we), 64'(0));
        chk({tag, ".im_addr"},  64'(sel ? 10'(im_addr_s) : im_addr), 64'(0));
        chk({tag, ".im_wdata"}, 64'(sel ? im_wdata_s : im_wdata), 64'(0));
        chk({tag, ".cpu_hold"}, 64'(sel ? cpu_hold_s : cpu_hold), 64'(1));
        chk({tag, ".done"},     64'(sel ? done_s : done), 64'(0));
        chk({tag, ".error"},    64'(sel ? error_s : error), 64'(0));
        chk({tag, ".words"},    64'(sel ? words_loaded_s : words_loaded), 64'(0));
    endtask

    // start_at: data-byte index after which an idle cycle carries a start pulse (-1: none).
    task automatic run_frame(input bit gap, input int start_at);
        wr_q.delete();
        wrs_q.delete();
        pulse_start();
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i]);
            if (i == frame.size() - 1) break;
            if (gap || (i - 2) == start_at) begin
                start = ((i - 2) == start_at);
                @(posedge clock); #1;
                start = 1'b0;
            end
        end
    endtask

    // Frame-level reference: decode header, words and checksum straight from the byte list.
    task automatic check_frame(input string tag);
        int          n, maxw, nw;
        logic [7:0]  x;
        logic [31:0] w;
        bit          exp_done, exp_err;
        wr_t         q[$];
        n    = int'({frame[0], frame[1]});
        maxw = sel ? 4 : 1024;
        if (n > maxw) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            nw       = 0;
        end else begin
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) x ^= frame[2 + i];
            exp_done = (frame[2 + 4 * n] == x);
            exp_err  = !exp_done;
            nw       = n;
        end
        chk({tag, ".done"},     64'(sel ? done_s : done), 64'(exp_done));
        chk({tag, ".error"},    64'(sel ? error_s : error), 64'(exp_err));
        chk({tag, ".cpu_hold"}, 64'(sel ? cpu_hold_s : cpu_hold), 64'(!exp_done));
        chk({tag, ".in_ready"}, 64'(cur_ready()), 64'(0));
        chk({tag, ".words"},    64'(sel ? words_loaded_s : words_loaded), 64'(nw));
        if (sel) q = wrs_q; else q = wr_q;
        chk({tag, ".n_writes"}, 64'(q.size()), 64'(nw));
        for (int i = 0; i < nw && i < q.size(); i++) begin
            w = {frame[2 + 4 * i], frame[3 + 4 * i], frame[4 + 4 * i], frame[5 + 4 * i]};
            chk($sformatf("%s.addr%0d", tag, i), 64'(q[i].addr), 64'(i));
            chk($sformatf("%s.data%0d", tag, i), 64'(q[i].data), 64'(w));
            chk($sformatf("%s.wl%0d", tag, i),   64'(q[i].wl), 64'(i + 1));
        end
    endtask

    task automatic set_frame(input logic [7:0] hi, input logic [7:0] lo,
                             input logic [31:0] words[$], input logic [7:0] cs);
        frame.delete();
        frame.push_back(hi);
        frame.push_back(lo);
        foreach (words[i]) begin
            frame.push_back(words[i][31:24]);
            frame.push_back(words[i][23:16]);
            frame.push_back(words[i][15:8]);
            frame.push_back(words[i][7:0]);
        end
        frame.push_back(cs);
    endtask

    initial begin
        logic [31:0] ws[$];
        logic [7:0]  x, b;
        int          n;

        // Reset state.
        do_reset();
        check_reset_outputs("reset");
        reset = 1'b0;

        // Two-word image, correct checksum.
        ws = '{32'h3C080001, 32'h21090005};
        set_frame(8'h00, 8'h02, ws, 8'h18);
        run_frame(1'b0, -1);
        check_frame("two_word_ok");

        // Same image, wrong checksum.
        set_frame(8'h00, 8'h02, ws, 8'h00);
        run_frame(1'b0, -1);
        check_frame("two_word_bad");

        // Empty image.
        ws = {};
        set_frame(8'h00, 8'h00, ws, 8'h00);
        run_frame(1'b0, -1);
        check_frame("empty_ok");
        set_frame(8'h00, 8'h00, ws, 8'h01);
        run_frame(1'b0, -1);
        check_frame("empty_bad");

        // Random frames, random checksum corruption and pacing.
        for (int k = 0; k < 8; k++) begin
            n = int'($urandom_range(1, 6));
            frame.delete();
            frame.push_back(8'h00);
            frame.push_back(8'(n));
            x = 8'h00;
            for (int j = 0; j < 4 * n; j++) begin
                b = 8'($urandom);
                frame.push_back(b);
                x ^= b;
            end
            if ($urandom_range(0, 1) == 1) x ^= 8'($urandom_range(1, 255));
            frame.push_back(x);
            run_frame(1'($urandom_range(0, 1)), -1);
            check_frame($sformatf("rnd%0d", k));
        end

        // Reset in the middle of the data phase, then a fresh one-word load.
        ws = '{32'h3C080001, 32'h21090005};
        set_frame(8'h00, 8'h02, ws, 8'h18);
        wr_q.delete();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(frame[i]);
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        ws = '{32'hDEADBEEF};
        set_frame(8'h00, 8'h01, ws, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
        run_frame(1'b0, -1);
        check_frame("after_reset");

        // Half-rate stream with a start pulse during DATA.
        ws = '{32'h3C080001, 32'h21090005};
        set_frame(8'h00, 8'h02, ws, 8'h18);
        run_frame(1'b1, 2);
        check_frame("half_rate_start");

        // Small IM: length overflow, then exactly-full image.
        sel = 1'b1;
        do_reset();
        check_reset_outputs("small_reset");
        reset = 1'b0;
        frame = '{8'h00, 8'h05};
        run_frame(1'b0, -1);
        check_frame("small_overflow");
        in_data  = 8'hAA;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            chk("small_overflow.ready_low", 64'(in_ready_s), 64'(0));
        end
        in_valid = 1'b0;
        chk("small_overflow.no_we", 64'(wrs_q.size()), 64'(0));

        ws = '{32'h01020304, 32'h11223344, 32'hA5A55A5A, 32'hFFFF0000};
        x = 8'h00;
        foreach (ws[i]) x ^= ws[i][31:24] ^ ws[i][23:16] ^ ws[i][15:8] ^ ws[i][7:0];
        set_frame(8'h00, 8'h04, ws, x);
        run_frame(1'b0, -1);
        check_frame("small_full");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
Writer side of the instruction-memory load path. Accepts a framed byte stream (valid/ready), packs bytes into 32-bit instruction words in the same big-endian hex order as the IM image files, and writes them into the IM word array from address 0. It holds the CPU in reset until a complete, checksum-verified image is loaded. It sits between a host byte source (UART receiver or bench driver) and the IM write port / CPU reset.

Parameters:
IM_ADDR_W, 10, IM word-address width; the image holds at most 2**IM_ADDR_W words.
LEN_W, 16, width of the word-count field in the frame header.

Ports:
clock      in   1          system clock
reset      in   1          synchronous, active-high reset
start      in   1          one-cycle pulse that arms a new load; honoured only in IDLE, DONE or ERROR
in_data    in   8          stream byte
in_valid   in   1          byte present
in_ready   out  1          loader can accept a byte
im_we      out  1          IM write strobe, one cycle per word
im_addr    out  IM_ADDR_W  IM word address
im_wdata   out  32         instruction word
cpu_hold   out  1          high holds the CPU in reset
done       out  1          image loaded and verified; sticky
error      out  1          load failed; sticky
words_loaded out LEN_W     words written so far in the current load

Behaviour:
- Ports are named clock and reset. Reset is synchronous and active-high, on one clock.
- Reset (including mid-load): state is IDLE. in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0. A partial image stays in IM but is not reported as done.
- Frame format: LEN_HI, LEN_LO (word count N, big-endian), then 4*N data bytes, each word MSB first, then a CSUM byte equal to the XOR of all 4*N data bytes.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR.
- A byte transfers on a cycle where in_valid=1 and in_ready=1. in_ready=1 only in LEN_HI, LEN_LO, DATA and CSUM. in_valid in other states is ignored and no byte is consumed.
- IDLE/DONE/ERROR, on start: go to LEN_HI. Set cpu_hold=1; clear done, error, words_loaded, the byte counter, address and the running XOR. start in any other state is ignored.
- LEN_HI → LEN_LO after one byte.
- LEN_LO, after one byte:
  - N=0 → CSUM.
  - N > 2**IM_ADDR_W → ERROR on the next cycle; the overflowing length is never written.
  - otherwise → DATA.
- DATA: shift each byte into the word register and XOR it into the running checksum.
  - On the 4th byte of a word, the next cycle drives im_we=1 for exactly one cycle, with im_addr equal to the word index and im_wdata equal to the packed word.
  - words_loaded increments in the same cycle as that strobe.
  - in_ready stays 1 during the strobe cycle, so back-to-back bytes are accepted at full rate.
  - After word N-1 is accepted → CSUM.
- CSUM, after one byte:
  - match → DONE: done=1, cpu_hold=0 (both registered, asserted the cycle after acceptance).
  - mismatch → ERROR: error=1, cpu_hold stays 1.
- The address counter is IM_ADDR_W+1 bits internally, so N = 2**IM_ADDR_W reaches CSUM without wrap.
- No timeout: a stalled stream simply waits.

Decomposition:
- Shared package mips_load_pkg holds:
  - the state encoding constants for IDLE..ERROR;
  - the header byte count constant (2);
  - the bytes-per-word constant (4).
- One sub-module is natural: byte_word_packer. It takes the byte, a valid and a clear; it outputs the 32-bit word, word_valid and the running XOR.

Test Plan:
- Reset, then start, then frame 00 02 | 3C 08 00 01 | 21 09 00 05 | CSUM=(XOR of the 8 bytes)=0x18 → im_we at addr 0 with 3C080001, then at addr 1 with 21090005; done=1, cpu_hold=0, words_loaded=2.
- Same frame with CSUM=0x00 → both words written; error=1, done=0, cpu_hold=1.
- Header 00 00 followed by CSUM 00 → no im_we; done=1. Header 00 00 followed by CSUM 01 → error=1.
- With IM_ADDR_W=2, header 00 05 → ERROR; in_ready=0 from the cycle after LEN_LO; no im_we.
- reset asserted after 5 data bytes → all outputs return to reset values. A fresh start plus a complete 1-word frame then loads at addr 0.
- in_valid toggling every other cycle, plus a start pulse during DATA → start is ignored; the words are identical to the full-rate case.
